// File: rtl/pipe_run_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_run_ctrl
//   Initiator side of the pipeline stage-enable sequencer handshake.
//   Launches a run on go, follows the sequencer's stage-enable vector through
//   fill, full-run and drain, requests a stop on a cycle limit, a halt or an
//   abort, then pulses done. Counts full-pipe (RUN) cycles and flags protocol
//   errors on the stage-enable vector.
//
// Ports
//   CLK         in   clock, rising edge
//   RSTN        in   asynchronous active-low reset
//   go          in   run request, accepted only when idle
//   step_count  in   full-pipe cycle limit, latched on accepted go (0 = none)
//   halt        in   HLT instruction decoded (honoured in FILL and RUN)
//   abort       in   external stop request (honoured in FILL and RUN)
//   stage_en    in   4-bit stage-enable vector from the sequencer
//   start       out  start request to the sequencer
//   stop        out  stop request to the sequencer
//   busy        out  run in progress (FILL, RUN, DRAIN)
//   done        out  one-cycle end-of-run pulse
//   run_cycles  out  RUN-state cycle count of the current or last run
//   err         out  sticky protocol error, cleared by the next accepted go
// ---------------------------------------------------------------------------
module pipe_run_ctrl #(
   parameter int unsigned CW = 16
) (
   input  logic          CLK,
   input  logic          RSTN,
   input  logic          go,
   input  logic [CW-1:0] step_count,
   input  logic          halt,
   input  logic          abort,
   input  logic [3:0]    stage_en,
   output logic          start,
   output logic          stop,
   output logic          busy,
   output logic          done,
   output logic [CW-1:0] run_cycles,
   output logic          err
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FILL,
      S_RUN,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] step_q, step_d;
   logic [CW-1:0] cyc_q, cyc_d;
   logic          stop_pend_q, stop_pend_d;
   logic          err_q, err_d;

   logic          code_legal;
   logic          proto_err;
   logic          limit_hit;
   logic          en_empty;
   logic          en_full;

   assign en_empty = (stage_en == 4'b0000);
   assign en_full  = (stage_en == 4'b1111);

   // Only the thermometer fill/drain codes are ever produced by the sequencer.
   always_comb begin
      code_legal = 1'b0;
      case (stage_en)
         4'b0000, 4'b0001, 4'b0011, 4'b0111,
         4'b1111, 4'b1110, 4'b1100, 4'b1000: code_legal = 1'b1;
         default:                            code_legal = 1'b0;
      endcase
   end

   always_comb begin
      proto_err = !code_legal;
      if (((state_q == S_IDLE) || (state_q == S_DONE)) && !en_empty)
         proto_err = 1'b1;
      if ((state_q == S_RUN) && en_empty)
         proto_err = 1'b1;
   end

   // Compared against the pre-increment count so the run lasts exactly
   // step_count RUN cycles.
   assign limit_hit = (step_q != '0) && (cyc_q == (step_q - CW'(1)));

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         state_q     <= S_IDLE;
         step_q      <= '0;
         cyc_q       <= '0;
         stop_pend_q <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         step_q      <= step_d;
         cyc_q       <= cyc_d;
         stop_pend_q <= stop_pend_d;
         err_q       <= err_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      step_d      = step_q;
      cyc_d       = cyc_q;
      stop_pend_d = stop_pend_q;
      err_d       = err_q | proto_err;

      case (state_q)
         S_IDLE: begin
            // An accepted go starts from a clean error state.
            if (go) begin
               step_d      = step_count;
               cyc_d       = '0;
               err_d       = 1'b0;
               stop_pend_d = 1'b0;
               state_d     = S_FILL;
            end
         end

         S_FILL: begin
            // The sequencer only honours stop once full, so remember it.
            if (halt || abort)
               stop_pend_d = 1'b1;
            if (proto_err)
               state_d = S_DONE;
            else if (en_full)
               state_d = S_RUN;
         end

         S_RUN: begin
            if (cyc_q != '1)
               cyc_d = cyc_q + CW'(1);
            if (proto_err)
               state_d = S_DONE;
            else if (stop_pend_q || halt || abort || limit_hit)
               state_d = S_DRAIN;
         end

         S_DRAIN: begin
            if (proto_err || en_empty)
               state_d = S_DONE;
         end

         S_DONE: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign start      = (state_q == S_FILL)  && en_empty;
   assign stop       = (state_q == S_DRAIN) && en_full;
   assign busy       = (state_q == S_FILL) || (state_q == S_RUN) || (state_q == S_DRAIN);
   assign done       = (state_q == S_DONE);
   assign run_cycles = cyc_q;
   assign err        = err_q;

endmodule

// File: tb/tb_pipe_run_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_run_ctrl
//   Directed bench for pipe_run_ctrl with a behavioural sequencer attached.
//   Cycle c1 is the first cycle after the edge that accepts go.
// ---------------------------------------------------------------------------
module tb_pipe_run_ctrl;

   localparam int unsigned CW = 16;

   logic          CLK;
   logic          RSTN;
   logic          go;
   logic [CW-1:0] step_count;
   logic          halt;
   logic          abort;
   logic [3:0]    stage_en;
   logic          start;
   logic          stop;
   logic          busy;
   logic          done;
   logic [CW-1:0] run_cycles;
   logic          err;

   logic [3:0]    seq_q;
   logic          seq_clr;
   logic          force_en;
   logic [3:0]    force_val;

   // {start, stop, busy, done} per cycle of the last trace
   logic [3:0]    tr [0:63];

   int n_tests;
   int n_fail;

   pipe_run_ctrl #(.CW(CW)) dut (
      .CLK        (CLK),
      .RSTN       (RSTN),
      .go         (go),
      .step_count (step_count),
      .halt       (halt),
      .abort      (abort),
      .stage_en   (stage_en),
      .start      (start),
      .stop       (stop),
      .busy       (busy),
      .done       (done),
      .run_cycles (run_cycles),
      .err        (err)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Sequencer model: fills one stage per cycle after start, holds full until
   // stop, then drains one stage per cycle.
   always @(posedge CLK or negedge RSTN) begin
      if (!RSTN)
         seq_q <= 4'b0000;
      else if (seq_clr)
         seq_q <= 4'b0000;
      else begin
         case (seq_q)
            4'b0000: if (start) seq_q <= 4'b0001;
            4'b0001: seq_q <= 4'b0011;
            4'b0011: seq_q <= 4'b0111;
            4'b0111: seq_q <= 4'b1111;
            4'b1111: if (stop) seq_q <= 4'b1110;
            4'b1110: seq_q <= 4'b1100;
            4'b1100: seq_q <= 4'b1000;
            4'b1000: seq_q <= 4'b0000;
            default: seq_q <= 4'b0000;
         endcase
      end
   end

   assign stage_en = force_en ? force_val : seq_q;

   // Issues go at c0, then runs n cycles applying the per-cycle stimulus
   // (0 = unused) and recording outputs 1 time unit after the inputs settle.
   task automatic run_trace(input logic [CW-1:0] sc, input int n, input int go_a,
                            input int go_b, input int halt_at, input int abort_at,
                            input int bad_at);
      step_count = sc;
      go = 1'b1;
      @(posedge CLK); #1;
      go = 1'b0;
      step_count = '0;
      for (int c = 1; c <= n; c++) begin
         go       = (c == go_a) || (c == go_b);
         halt     = (c == halt_at);
         abort    = (c == abort_at);
         force_en = (c == bad_at);
         seq_clr  = (c == bad_at);
         #1;
         tr[c] = {start, stop, busy, done};
         @(posedge CLK); #1;
      end
      go = 1'b0; halt = 1'b0; abort = 1'b0; force_en = 1'b0; seq_clr = 1'b0;
   endtask

   task automatic test_reset();
      n_tests++;
      if ({start, stop, busy, done} !== 4'b0000) begin
         n_fail++;
         $display("FAIL reset_outputs got %b want 0000", {start, stop, busy, done});
      end
      n_tests++;
      if (run_cycles !== '0) begin
         n_fail++;
         $display("FAIL reset_run_cycles got %0d want 0", run_cycles);
      end
      n_tests++;
      if (err !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_err got %b want 0", err);
      end
   endtask

   task automatic test_basic();
      logic [3:0] exp;
      run_trace(3, 16, 0, 0, 0, 0, 0);
      for (int c = 1; c <= 16; c++) begin
         exp = {c == 1, c == 9, (c >= 1) && (c <= 13), c == 14};
         n_tests++;
         if (tr[c] !== exp) begin
            n_fail++;
            $display("FAIL basic_c%0d got %b want %b", c, tr[c], exp);
         end
      end
      n_tests++;
      if (run_cycles !== 16'd3) begin
         n_fail++;
         $display("FAIL basic_run_cycles got %0d want 3", run_cycles);
      end
      n_tests++;
      if (err !== 1'b0) begin
         n_fail++;
         $display("FAIL basic_err got %b want 0", err);
      end
   endtask

   task automatic test_step_one();
      logic [3:0] exp;
      run_trace(1, 13, 0, 0, 0, 0, 0);
      for (int c = 1; c <= 13; c++) begin
         exp = {c == 1, c == 7, (c >= 1) && (c <= 11), c == 12};
         n_tests++;
         if (tr[c] !== exp) begin
            n_fail++;
            $display("FAIL step1_c%0d got %b want %b", c, tr[c], exp);
         end
      end
      n_tests++;
      if (run_cycles !== 16'd1) begin
         n_fail++;
         $display("FAIL step1_run_cycles got %0d want 1", run_cycles);
      end
   endtask

   task automatic test_halt();
      logic [3:0] exp;
      run_trace(0, 18, 0, 0, 10, 0, 0);
      for (int c = 1; c <= 18; c++) begin
         exp = {c == 1, c == 11, (c >= 1) && (c <= 15), c == 16};
         n_tests++;
         if (tr[c] !== exp) begin
            n_fail++;
            $display("FAIL halt_c%0d got %b want %b", c, tr[c], exp);
         end
      end
      n_tests++;
      if (run_cycles !== 16'd5) begin
         n_fail++;
         $display("FAIL halt_run_cycles got %0d want 5", run_cycles);
      end
   endtask

   task automatic test_abort_fill();
      logic [3:0] exp;
      run_trace(0, 14, 0, 0, 0, 2, 0);
      for (int c = 1; c <= 14; c++) begin
         exp = {c == 1, c == 7, (c >= 1) && (c <= 11), c == 12};
         n_tests++;
         if (tr[c] !== exp) begin
            n_fail++;
            $display("FAIL abort_c%0d got %b want %b", c, tr[c], exp);
         end
      end
      n_tests++;
      if (run_cycles !== 16'd1) begin
         n_fail++;
         $display("FAIL abort_run_cycles got %0d want 1", run_cycles);
      end
   endtask

   task automatic test_halt_and_abort();
      logic [3:0] exp;
      run_trace(0, 15, 0, 0, 8, 8, 0);
      for (int c = 1; c <= 15; c++) begin
         exp = {c == 1, c == 9, (c >= 1) && (c <= 13), c == 14};
         n_tests++;
         if (tr[c] !== exp) begin
            n_fail++;
            $display("FAIL both_c%0d got %b want %b", c, tr[c], exp);
         end
      end
      n_tests++;
      if (run_cycles !== 16'd3) begin
         n_fail++;
         $display("FAIL both_run_cycles got %0d want 3", run_cycles);
      end
   endtask

   task automatic test_go_ignored();
      logic [3:0] exp;
      run_trace(3, 18, 7, 14, 0, 0, 0);
      for (int c = 1; c <= 18; c++) begin
         exp = {c == 1, c == 9, (c >= 1) && (c <= 13), c == 14};
         n_tests++;
         if (tr[c] !== exp) begin
            n_fail++;
            $display("FAIL goign_c%0d got %b want %b", c, tr[c], exp);
         end
      end
      n_tests++;
      if (run_cycles !== 16'd3) begin
         n_fail++;
         $display("FAIL goign_run_cycles got %0d want 3", run_cycles);
      end
   endtask

   task automatic test_bad_code();
      logic [3:0] exp;
      force_val = 4'b0101;
      run_trace(0, 10, 0, 0, 0, 0, 7);
      for (int c = 1; c <= 10; c++) begin
         exp = {c == 1, 1'b0, (c >= 1) && (c <= 7), c == 8};
         n_tests++;
         if (tr[c] !== exp) begin
            n_fail++;
            $display("FAIL bad_c%0d got %b want %b", c, tr[c], exp);
         end
      end
      n_tests++;
      if (err !== 1'b1) begin
         n_fail++;
         $display("FAIL bad_err got %b want 1", err);
      end
      n_tests++;
      if (run_cycles !== 16'd2) begin
         n_fail++;
         $display("FAIL bad_run_cycles got %0d want 2", run_cycles);
      end
      // A following go clears err and runs normally.
      run_trace(3, 15, 0, 0, 0, 0, 0);
      n_tests++;
      if (err !== 1'b0) begin
         n_fail++;
         $display("FAIL bad_err_cleared got %b want 0", err);
      end
      n_tests++;
      if (tr[14] !== 4'b0001) begin
         n_fail++;
         $display("FAIL bad_rerun_done got %b want 0001", tr[14]);
      end
      // Illegal code while idle flags err without starting anything.
      force_en = 1'b1;
      seq_clr  = 1'b1;
      @(posedge CLK); #1;
      force_en = 1'b0;
      seq_clr  = 1'b0;
      #1;
      n_tests++;
      if ({err, busy, done} !== 3'b100) begin
         n_fail++;
         $display("FAIL idle_bad got err/busy/done %b want 100", {err, busy, done});
      end
      @(posedge CLK); #1;
   endtask

   task automatic test_reset_in_drain();
      logic [3:0] exp;
      run_trace(3, 10, 0, 0, 0, 0, 0);
      n_tests++;
      if (tr[9] !== 4'b0110) begin
         n_fail++;
         $display("FAIL rst_pre_drain got %b want 0110", tr[9]);
      end
      RSTN = 1'b0;
      #1;
      n_tests++;
      if ({start, stop, busy, done, err} !== 5'b00000) begin
         n_fail++;
         $display("FAIL rst_mid_outputs got %b want 00000", {start, stop, busy, done, err});
      end
      n_tests++;
      if (run_cycles !== '0) begin
         n_fail++;
         $display("FAIL rst_mid_run_cycles got %0d want 0", run_cycles);
      end
      @(posedge CLK); #1;
      RSTN = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(posedge CLK); #1;
         n_tests++;
         if ({busy, done} !== 2'b00) begin
            n_fail++;
            $display("FAIL rst_no_done_%0d got busy/done %b want 00", c, {busy, done});
         end
      end
      run_trace(3, 15, 0, 0, 0, 0, 0);
      for (int c = 1; c <= 15; c++) begin
         exp = {c == 1, c == 9, (c >= 1) && (c <= 13), c == 14};
         n_tests++;
         if (tr[c] !== exp) begin
            n_fail++;
            $display("FAIL rst_rerun_c%0d got %b want %b", c, tr[c], exp);
         end
      end
      n_tests++;
      if (run_cycles !== 16'd3) begin
         n_fail++;
         $display("FAIL rst_rerun_run_cycles got %0d want 3", run_cycles);
      end
   endtask

   initial begin
      n_tests    = 0;
      n_fail     = 0;
      RSTN       = 1'b0;
      go         = 1'b0;
      step_count = '0;
      halt       = 1'b0;
      abort      = 1'b0;
      seq_clr    = 1'b0;
      force_en   = 1'b0;
      force_val  = 4'b0101;
      repeat (2) @(posedge CLK);
      #1;
      test_reset();
      RSTN = 1'b1;
      @(posedge CLK); #1;

      test_basic();
      test_step_one();
      test_halt();
      test_abort_fill();
      test_halt_and_abort();
      test_go_ignored();
      test_bad_code();
      test_reset_in_drain();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
